rom_arbiter: RTL and testbench

- Shares one synchronous single-port ROM between NUM_REQ requesters. The ROM has a 1-cycle read latency and an enable input.
- Round-robin arbitration with a valid/ready request handshake per requester.
- Returns read data on a shared data bus, tagged by a one-hot response-valid vector.
- Sits between the ROM instance and its consumers (e.g. several tile/texture fetch units).

---
 rtl/rom_arb_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/rom_arbiter.sv | 93 +++++++++
 tb/tb_rom_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// Shared constants and width helpers for the ROM arbiter slice.
package rom_arb_pkg;

  localparam int NUM_REQ_MAX = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Pointer/index width, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module rr_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_grant
);

  int               pos;
  logic [IDX_W-1:0] pos_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    pos       = 0;
    pos_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos     = (int'(rr_ptr) + k) % NUM_REQ;
      pos_idx = IDX_W'(pos);
      if (!any_grant && req[pos_idx]) begin
        any_grant      = 1'b1;
        grant[pos_idx] = 1'b1;
        grant_idx      = pos_idx;
      end
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin sharing of a 1-cycle-latency ROM between NUM_REQ requesters.
// Define ROM_ARB_OUTREG_EN to add an output register on rsp_valid/rsp_data.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int ROM_WIDTH     = 1,
  parameter int ROM_ADDR_BITS = 14
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*ROM_ADDR_BITS-1:0] req_addr,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [ROM_WIDTH-1:0]             rsp_data,
  output logic [ROM_ADDR_BITS-1:0]         rom_addr,
  output logic                             rom_enable,
  input  logic [ROM_WIDTH-1:0]             rom_data
);

  localparam int IDX_W = idx_width(NUM_REQ);

  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     grant_idx;
  logic [NUM_REQ-1:0]   grant;
  logic                 any_grant;
  logic [NUM_REQ-1:0]   rsp_tag;
  logic [ROM_WIDTH-1:0] data_hold;
  logic [ROM_WIDTH-1:0] rsp_data_c;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign req_ready  = grant;
  assign rom_enable = |(req_valid & grant);

  always_comb begin
    rom_addr = '0;
    if (any_grant) rom_addr = req_addr[grant_idx*ROM_ADDR_BITS +: ROM_ADDR_BITS];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (rom_enable) begin
      rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // The tag trails the accept by the ROM latency; reset drops any read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_tag   <= '0;
      data_hold <= '0;
    end else begin
      rsp_tag <= rom_enable ? grant : '0;
      if (|rsp_tag) data_hold <= rom_data;
    end
  end

  assign rsp_data_c = (|rsp_tag) ? rom_data : data_hold;

`ifdef ROM_ARB_OUTREG_EN
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic [ROM_WIDTH-1:0] rsp_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_tag;
      rsp_data_q  <= rsp_data_c;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
`else
  assign rsp_valid = rsp_tag;
  assign rsp_data  = rsp_data_c;
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter with a behavioural arbitration/latency model.
module tb_rom_arbiter;

  localparam int N  = 4;
  localparam int AB = 14;
  localparam int W  = 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*AB-1:0] req_addr = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic [AB-1:0]  rom_addr;
  logic           rom_enable;
  logic [W-1:0]   rom_data;

  logic [W-1:0]   rom_mem [1<<AB];
  logic [AB-1:0]  addrs [N];

  int total = 0;
  int bad   = 0;

  // Reference model state: next-search pointer and response pipeline
  int           m_ptr;
  logic [N-1:0] cur_v, mid_v;
  logic [W-1:0] cur_d, mid_d;

  always #5 clk = ~clk;

  always @(posedge clk) if (rom_enable) rom_data <= rom_mem[rom_addr];

  rom_arbiter #(
    .NUM_REQ       (N),
    .ROM_WIDTH     (W),
    .ROM_ADDR_BITS (AB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rom_addr   (rom_addr),
    .rom_enable (rom_enable),
    .rom_data   (rom_data)
  );

  task checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task applyStimulus(input logic [N-1:0] v);
    req_valid = v;
    for (int i = 0; i < N; i++) req_addr[i*AB +: AB] = addrs[i];
  endtask

  function automatic int pickGrant(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // One clock: check outputs mid-cycle, then advance the model across the edge
  task runCycle(output int g);
    logic [N-1:0]  exp_ready;
    logic [AB-1:0] exp_addr;
    logic [W-1:0]  nd;
    @(negedge clk);
    g         = pickGrant(req_valid, m_ptr);
    exp_ready = (g >= 0) ? (N'(1) << g) : '0;
    exp_addr  = (g >= 0) ? addrs[g] : '0;
    nd        = (g >= 0) ? rom_mem[addrs[g]] : '0;
    checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
    checkOutput("rom_enable", 32'(rom_enable), 32'(g >= 0));
    checkOutput("rom_addr", 32'(rom_addr), 32'(exp_addr));
    checkOutput("rsp_valid", 32'(rsp_valid), 32'(cur_v));
    checkOutput("rsp_data", 32'(rsp_data), 32'(cur_d));
    @(posedge clk);
`ifdef ROM_ARB_OUTREG_EN
    if (|mid_v) cur_d = mid_d;
    cur_v = mid_v;
    mid_v = exp_ready;
    mid_d = nd;
`else
    if (g >= 0) cur_d = nd;
    cur_v = exp_ready;
`endif
    if (g >= 0) m_ptr = (g + 1) % N;
    #1;
  endtask

  task applyReset;
    rst_n     = 1'b0;
    req_valid = '0;
    m_ptr     = 0;
    cur_v     = '0;
    mid_v     = '0;
    cur_d     = '0;
    mid_d     = '0;
    @(negedge clk);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("reset_rom_enable", 32'(rom_enable), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int g;
    logic [N-1:0] v;
    for (int a = 0; a < (1 << AB); a++) rom_mem[a] = W'($urandom);
    rom_mem[5] = 1'b1;
    for (int i = 0; i < N; i++) addrs[i] = '0;

    // Reset, then idle
    applyReset();
    applyStimulus('0);
    repeat (10) runCycle(g);

    // Lone requester 2 reading word 5
    addrs[2] = AB'(5);
    applyStimulus(4'b0100);
    runCycle(g);
    applyStimulus('0);
    repeat (3) runCycle(g);

    // Pointer sits at 3: requesters 0 and 3 contend, 3 first then wrap to 0
    addrs[0] = AB'($urandom);
    addrs[3] = AB'($urandom);
    applyStimulus(4'b1001);
    runCycle(g);
    applyStimulus(4'b0001);
    runCycle(g);
    applyStimulus('0);
    repeat (3) runCycle(g);

    // Reset in the cycle after an accept drops the response and the pointer
    addrs[2] = AB'(5);
    applyStimulus(4'b0100);
    runCycle(g);
    applyReset();
    applyStimulus('0);
    repeat (3) runCycle(g);

    // All requesters continuously valid with distinct addresses
    for (int i = 0; i < N; i++) addrs[i] = AB'(i * 37 + 1 + ($urandom % 30) * 200);
    applyStimulus(4'b1111);
    repeat (8) runCycle(g);
    applyStimulus('0);
    repeat (3) runCycle(g);

    // Single requester held valid is granted every cycle
    addrs[1] = AB'($urandom);
    applyStimulus(4'b0010);
    repeat (6) runCycle(g);
    applyStimulus('0);
    repeat (3) runCycle(g);

    // Random traffic obeying hold-until-accepted
    v = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i]) begin
          v[i]     = 1'($urandom_range(0, 1));
          addrs[i] = AB'($urandom);
        end
      end
      applyStimulus(v);
      runCycle(g);
      if (g >= 0) v[g] = 1'b0;
    end
    applyStimulus('0);
    repeat (3) runCycle(g);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
